// File: rtl/clock_core.sv
// rtl/clock_core.sv - hours/minutes/seconds timekeeper with edge-triggered setup load
// Optional hourly chime is built only when CLOCK_CHIME_EN is defined.
module clock_core #(
  parameter int CLK_HZ       = 62_500_000,
  parameter int CHIME_CYCLES = 62_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       setup_ready,
  input  logic [6:0] setup_hour,
  input  logic [6:0] setup_minute,
  output logic [6:0] hour,
  output logic [6:0] minute,
  output logic [6:0] second,
  output logic       sec_tick,
  output logic       loaded,
  output logic       load_err,
  output logic       chime
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  if (CLK_HZ < 2 || CHIME_CYCLES < 1) begin : g_param_check
    $error("clock_core: CLK_HZ must be >= 2 and CHIME_CYCLES >= 1");
  end

  logic [PW-1:0] presc;
  logic          ready_q;
  logic          setup_ev;
  logic          setup_ok;
  logic          wrap;
  logic          sec_wrap;
  logic          min_wrap;

  assign setup_ev = setup_ready && !ready_q;
  assign setup_ok = (setup_hour <= 7'd23) && (setup_minute <= 7'd59);
  assign wrap     = (presc == PRESC_MAX);
  assign sec_wrap = (second == 7'd59);
  assign min_wrap = (minute == 7'd59);

  // A valid load takes priority over a coincident prescaler wrap: no tick, no carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      presc    <= '0;
      hour     <= '0;
      minute   <= '0;
      second   <= '0;
      sec_tick <= 1'b0;
      loaded   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      ready_q  <= setup_ready;
      sec_tick <= 1'b0;
      loaded   <= 1'b0;
      load_err <= 1'b0;
      if (setup_ev && setup_ok) begin
        hour   <= setup_hour;
        minute <= setup_minute;
        second <= '0;
        presc  <= '0;
        loaded <= 1'b1;
      end else begin
        load_err <= setup_ev;
        if (wrap) begin
          presc    <= '0;
          sec_tick <= 1'b1;
          if (sec_wrap) begin
            second <= '0;
            if (min_wrap) begin
              minute <= '0;
              hour   <= (hour == 7'd23) ? 7'd0 : hour + 7'd1;
            end else begin
              minute <= minute + 7'd1;
            end
          end else begin
            second <= second + 7'd1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

`ifdef CLOCK_CHIME_EN
  localparam int CW = $clog2(CHIME_CYCLES + 1);

  logic [CW-1:0] chime_cnt;
  logic          rollover;

  assign rollover = wrap && !(setup_ev && setup_ok) && sec_wrap && min_wrap;

  // chime_cnt holds the remaining high cycles after the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      chime_cnt <= '0;
      chime     <= 1'b0;
    end else if (rollover) begin
      chime_cnt <= CW'(CHIME_CYCLES - 1);
      chime     <= 1'b1;
    end else if (chime_cnt != '0) begin
      chime_cnt <= chime_cnt - 1'b1;
    end else begin
      chime <= 1'b0;
    end
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_clock_core.sv
// tb/tb_clock_core.sv - self-checking bench for clock_core against a seconds-of-day model
// Chime checks follow CLOCK_CHIME_EN when it is defined for the whole build.
module tb_clock_core;

  localparam int CLK_HZ = 10;
  localparam int CHIME  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       setup_ready;
  logic [6:0] setup_hour;
  logic [6:0] setup_minute;
  logic [6:0] hour;
  logic [6:0] minute;
  logic [6:0] second;
  logic       sec_tick;
  logic       loaded;
  logic       load_err;
  logic       chime;

  always #5 clk = ~clk;

  clock_core #(.CLK_HZ(CLK_HZ), .CHIME_CYCLES(CHIME)) dut (
    .clk(clk), .reset(reset), .setup_ready(setup_ready),
    .setup_hour(setup_hour), .setup_minute(setup_minute),
    .hour(hour), .minute(minute), .second(second),
    .sec_tick(sec_tick), .loaded(loaded), .load_err(load_err), .chime(chime)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: time as seconds since midnight, prescaler as a plain integer.
  bit m_ready_q;
  int m_tod;
  int m_presc;
  int m_chime_left;
  bit m_tick, m_loaded, m_err;

  wire [24:0] dut_vec = {hour, minute, second, sec_tick, loaded, load_err, chime};

  function automatic logic [24:0] exp_vec();
    logic ch;
`ifdef CLOCK_CHIME_EN
    ch = (m_chime_left > 0);
`else
    ch = 1'b0;
`endif
    return {7'(m_tod / 3600), 7'((m_tod / 60) % 60), 7'(m_tod % 60),
            m_tick, m_loaded, m_err, ch};
  endfunction

  task automatic step();
    bit ev, roll;
    @(posedge clk);
    if (reset) begin
      m_ready_q = 0; m_tod = 0; m_presc = 0; m_chime_left = 0;
      m_tick = 0; m_loaded = 0; m_err = 0;
    end else begin
      ev = setup_ready && !m_ready_q;
      m_ready_q = setup_ready;
      m_tick = 0; m_loaded = 0; m_err = 0; roll = 0;
      if (ev && int'(setup_hour) <= 23 && int'(setup_minute) <= 59) begin
        m_tod = int'(setup_hour) * 3600 + int'(setup_minute) * 60;
        m_presc = 0;
        m_loaded = 1;
      end else begin
        if (ev) m_err = 1;
        if (m_presc == CLK_HZ - 1) begin
          m_presc = 0;
          m_tick = 1;
          m_tod = (m_tod + 1) % 86400;
          roll = (m_tod % 3600 == 0);
        end else begin
          m_presc++;
        end
      end
      if (roll) m_chime_left = CHIME;
      else if (m_chime_left > 0) m_chime_left--;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; setup_ready = 0; setup_hour = 0; setup_minute = 0;
    step(); step();
    n_checks++;
    if (dut_vec !== 25'd0) begin
      n_fail++; $display("FAIL reset_state got %h want %h", dut_vec, 25'd0);
    end
    reset = 0;
    step();
  endtask

  task automatic test_hold_load();
    int n_load = 0;
    setup_hour = 13; setup_minute = 45; setup_ready = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL hold_vec cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
      if (loaded) n_load++;
      if (i == 0) begin
        n_checks++;
        if ({hour, minute, second} !== {7'd13, 7'd45, 7'd0}) begin
          n_fail++; $display("FAIL hold_time got %0d:%0d:%0d want 13:45:0", hour, minute, second);
        end
      end
      n_checks++;
      if (sec_tick !== (i > 0 && i % CLK_HZ == 0)) begin
        n_fail++; $display("FAIL hold_tick cyc %0d got %b want %b", i, sec_tick, (i > 0 && i % CLK_HZ == 0));
      end
    end
    n_checks++;
    if (n_load != 1) begin
      n_fail++; $display("FAIL hold_load_count got %0d want 1", n_load);
    end
    setup_ready = 0;
    step();
  endtask

  task automatic test_rollover();
    int n_tick = 0;
    bit bad = 0;
    setup_hour = 23; setup_minute = 59; setup_ready = 1;
    step();
    setup_ready = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 0) setup_ready = 1;
      else if (i == 1 + int'($urandom_range(0, 15))) setup_ready = 0;
      if (i > 20) setup_ready = 0;
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL roll_vec cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
      if (hour > 23 || minute > 59 || second > 59) bad = 1;
      if (sec_tick) begin
        n_tick++;
        if (n_tick == 60) begin
          n_checks++;
          if ({hour, minute, second} !== 21'd0) begin
            n_fail++; $display("FAIL roll_midnight got %0d:%0d:%0d want 0:0:0", hour, minute, second);
          end
        end
      end
    end
    setup_ready = 0;
    n_checks++;
    if (n_tick != 60 || bad) begin
      n_fail++; $display("FAIL roll_range ticks %0d want 60, out_of_range %b want 0", n_tick, bad);
    end
  endtask

  task automatic test_load_err();
    logic [6:0] hs[4];
    logic [6:0] ms[4];
    hs[0] = 24; ms[0] = 10;
    hs[1] = 5;  ms[1] = 60;
    hs[2] = 7'($urandom_range(24, 127)); ms[2] = 7'($urandom_range(0, 59));
    hs[3] = 7'($urandom_range(0, 23));   ms[3] = 7'($urandom_range(60, 127));
    for (int k = 0; k < 4; k++) begin
      int n_err = 0;
      int n_load = 0;
      setup_hour = hs[k]; setup_minute = ms[k];
      for (int i = 0; i < 25; i++) begin
        setup_ready = (i >= 3 && i < 15);
        step();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++; $display("FAIL err_vec set %0d cyc %0d got %h want %h", k, i, dut_vec, exp_vec());
        end
        if (load_err) n_err++;
        if (loaded) n_load++;
      end
      n_checks++;
      if (n_err != 1 || n_load != 0) begin
        n_fail++; $display("FAIL err_count set %0d got err %0d load %0d want 1 0", k, n_err, n_load);
      end
    end
    setup_ready = 0;
  endtask

  task automatic test_random_loads();
    for (int k = 0; k < 8; k++) begin
      int gap = $urandom_range(0, 25);
      int hold = $urandom_range(1, 15);
      bit bad = ($urandom_range(0, 3) == 0);
      setup_hour   = bad ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 23));
      setup_minute = bad ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 59));
      for (int i = 0; i < gap + hold; i++) begin
        setup_ready = (i >= gap);
        step();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++; $display("FAIL rand_vec load %0d cyc %0d got %h want %h", k, i, dut_vec, exp_vec());
        end
      end
      setup_ready = 0;
    end
    step();
  endtask

  task automatic test_terminal_count();
    int guard = 0;
    while (m_presc != CLK_HZ - 1 && guard < 20) begin
      step(); guard++;
    end
    n_checks++;
    if (m_presc != CLK_HZ - 1) begin
      n_fail++; $display("FAIL tc_align got presc %0d want %0d", m_presc, CLK_HZ - 1);
    end
    setup_hour = 8; setup_minute = 30; setup_ready = 1;
    step();
    n_checks++;
    if ({loaded, sec_tick, hour, minute, second} !== {1'b1, 1'b0, 7'd8, 7'd30, 7'd0}) begin
      n_fail++; $display("FAIL tc_load got ld %b tick %b %0d:%0d:%0d want 1 0 8:30:0",
                         loaded, sec_tick, hour, minute, second);
    end
    for (int k = 1; k <= CLK_HZ; k++) begin
      step();
      n_checks++;
      if (sec_tick !== (k == CLK_HZ)) begin
        n_fail++; $display("FAIL tc_next_tick cyc %0d got %b want %b", k, sec_tick, (k == CLK_HZ));
      end
    end
    setup_ready = 0;
    step();
  endtask

  task automatic test_reset_mid();
    setup_hour = 7; setup_minute = 12; setup_ready = 1;
    step();
    setup_ready = 0;
    for (int i = 0; i < 33 * CLK_HZ; i++) step();
    n_checks++;
    if ({hour, minute, second} !== {7'd7, 7'd12, 7'd33}) begin
      n_fail++; $display("FAIL rst_pre got %0d:%0d:%0d want 7:12:33", hour, minute, second);
    end
    reset = 1; setup_ready = 1; setup_hour = 3; setup_minute = 4;
    step();
    n_checks++;
    if (dut_vec !== 25'd0) begin
      n_fail++; $display("FAIL rst_mid got %h want 0", dut_vec);
    end
    step();
    reset = 0;
    step();
    n_checks++;
    if ({loaded, hour, minute, second} !== {1'b1, 7'd3, 7'd4, 7'd0}) begin
      n_fail++; $display("FAIL rst_release_load got ld %b %0d:%0d:%0d want 1 3:4:0",
                         loaded, hour, minute, second);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rst_after cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    setup_ready = 0;
    step();
  endtask

  task automatic test_chime();
    int roll_i = -1;
    int n_chime = 0;
    int chime_at_roll = -1;
    setup_hour = 10; setup_minute = 59; setup_ready = 1;
    step();
    setup_ready = 0;
    for (int i = 0; i < 700; i++) begin
      if (roll_i >= 0 && i > roll_i + 20) break;
      if (roll_i >= 0 && i == roll_i + 2) begin
        setup_hour = 4; setup_minute = 20; setup_ready = 1;
      end else begin
        setup_ready = 0;
      end
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL chime_vec cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
      if (chime) n_chime++;
      if (roll_i < 0 && sec_tick && {hour, minute, second} == {7'd11, 7'd0, 7'd0}) begin
        roll_i = i;
        chime_at_roll = chime;
      end
    end
    setup_ready = 0;
    n_checks++;
    if (roll_i < 0) begin
      n_fail++; $display("FAIL chime_rollover_seen got none want 11:00:00 within 700 cycles");
    end
`ifdef CLOCK_CHIME_EN
    n_checks++;
    if (n_chime != CHIME || chime_at_roll != 1) begin
      n_fail++; $display("FAIL chime_len got %0d cycles start %0d want %0d start 1",
                         n_chime, chime_at_roll, CHIME);
    end
`else
    n_checks++;
    if (n_chime != 0) begin
      n_fail++; $display("FAIL chime_off got %0d high cycles want 0", n_chime);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_hold_load();
    test_rollover();
    test_load_err();
    test_random_loads();
    test_terminal_count();
    test_reset_mid();
    test_chime();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_core.md
# clock_core

Timekeeping core that consumes the time-setup handshake (`setup_ready`, `setup_hour`, `setup_minute`) and keeps running hours/minutes/seconds. It sits downstream of the setup logic and upstream of the display/BCD path. A setup is accepted once per rising edge of `setup_ready`, because that signal is held high for about one second. Between setups the core counts real time from a clock prescaler.

## Interface
- `CLK_HZ`, 62_500_000: clock cycles per second; prescaler terminal count is `CLK_HZ-1`.
- `CHIME_CYCLES`, 62_500_000: length of the hourly chime in cycles. Used only with `CLOCK_CHIME_EN`.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `setup_ready`  in  1  setup valid. A level held for many cycles; only its rising edge acts.
- `setup_hour`  in  7  requested hour, legal range 0..23.
- `setup_minute`  in  7  requested minute, legal range 0..59.
- `hour`  out  7  current hour, 0..23.
- `minute`  out  7  current minute, 0..59.
- `second`  out  7  current second, 0..59.
- `sec_tick`  out  1  one-cycle pulse when `second` advances.
- `loaded`  out  1  one-cycle pulse: setup accepted.
- `load_err`  out  1  one-cycle pulse: setup rejected (out of range).
- `chime`  out  1  hourly chime level. Constant 0 without `CLOCK_CHIME_EN`.

## Operation
- Reset clears the following to 0: `hour`, `minute`, `second`, prescaler, chime counter, `sec_tick`, `loaded`, `load_err`, `chime`, and the internal `ready_q` register.
- Edge detect:
  - `ready_q <= setup_ready` every cycle.
  - A setup event is `setup_ready && !ready_q`.
  - If `setup_ready` is already high when reset releases, exactly one setup event occurs on the first cycle after reset.
- Setup event with `setup_hour<=23` and `setup_minute<=59`:
  - `hour<=setup_hour`, `minute<=setup_minute`, `second<=0`, prescaler<=0.
  - `loaded` pulses.
- Setup event with an out-of-range value:
  - Time and prescaler are unchanged and counting continues.
  - `load_err` pulses.
- Holding `setup_ready` high never causes a reload and never stalls counting.
- Counting:
  - The prescaler counts 0..`CLK_HZ-1` and wraps to 0.
  - At wrap, `sec_tick` pulses and `second` increments.
  - `second` 59 → 0 carries into `minute`.
  - `minute` 59 → 0 carries into `hour`.
  - `hour` 23 → 0 on carry.
  - All carries resolve in the same cycle; no intermediate value such as 60 is ever visible.
- Arithmetic: the prescaler is sized with `$clog2(CLK_HZ)` bits. Time fields are 7-bit unsigned and are compared only against 59 and 23.
- Load and tick in the same cycle: the load wins. Prescaler goes to 0, `sec_tick` stays low, and no carry is applied.
- Reset mid-count or mid-chime returns to the reset state in the next cycle.

## Timing
- Setup latency: the setup event is detected at edge N, where `setup_ready` is sampled 1 and `ready_q` is 0. The new time is visible after edge N, and `loaded`/`load_err` are high for the cycle following edge N.
- After a load, the first `sec_tick` occurs exactly `CLK_HZ` cycles later.
- `sec_tick`, `loaded` and `load_err` are registered and high for exactly one cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `CLOCK_CHIME_EN` defined:
  - On the tick where `minute` and `second` both wrap to 0 (the hour rollover), `chime` goes high and stays high for `CHIME_CYCLES` cycles.
  - A load during the chime does not cut it short.
  - A second rollover during the chime restarts the count.
- `CLOCK_CHIME_EN` undefined: no chime counter is built and `chime` is tied to 0.

## Test plan
All scenarios use `CLK_HZ=10` and `CHIME_CYCLES=5`.
- Reset, then `setup_ready` held high for 30 cycles with 13/45 → exactly one `loaded` pulse; time reads 13:45:00; `sec_tick` occurs every 10 cycles with no reload while the level is held.
- Load 23:59, then run 600 cycles → `hour=0`, `minute=0`, `second=0` at the 60th tick; no value 24 or 60 is ever observed.
- `setup_ready` edge with 24/10, and separately with 5/60 → `load_err` pulses once each; time keeps running unchanged.
- `setup_ready` edge timed on the prescaler's terminal-count cycle → load applied, no `sec_tick` that cycle, next tick 10 cycles later.
- `reset` asserted during counting at 07:12:33 → all outputs 0 one cycle later; with `setup_ready` high across the reset release, one load occurs on the first cycle after reset.
- `CLOCK_CHIME_EN` defined: load 10:59, run to the rollover → `chime` high for exactly 5 cycles starting with the tick that produces 11:00:00. Without the macro, `chime` is always 0.
